// File: rtl/dfs_walker.sv
// Preorder (left-before-right) depth-first walker over a node memory, deferring right children to an external LIFO.
// Optional feature: define DFS_VISIT_COUNT_EN to add the saturating visit_count output.
module dfs_walker #(
  parameter int IDX_WIDTH  = 8,
  parameter int NODE_WIDTH = 2*IDX_WIDTH+3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDX_WIDTH-1:0]  root_idx,
  output logic                  node_rd_en,
  output logic [IDX_WIDTH-1:0]  node_addr,
  input  logic [NODE_WIDTH-1:0] node_rdata,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [IDX_WIDTH-1:0]  stk_din,
  input  logic [IDX_WIDTH-1:0]  stk_dout,
  input  logic                  stk_just_popped,
  input  logic                  stk_full,
  input  logic                  stk_empty,
  output logic                  visit_valid,
  output logic [IDX_WIDTH-1:0]  visit_idx,
  output logic                  visit_leaf,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef DFS_VISIT_COUNT_EN
  ,
  output logic [IDX_WIDTH:0]    visit_count
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    DECODE   = 3'd2,
    POP      = 3'd3,
    POP_WAIT = 3'd4
  } state_e;

  state_e               state_q;
  logic [IDX_WIDTH-1:0] cur_q;
  logic [IDX_WIDTH-1:0] node_addr_q;
  logic                 node_rd_en_q;
  logic                 stk_pop_q;
  logic                 busy_q;
  logic                 err_q;

  logic                 n_leaf_s;
  logic                 n_has_l_s;
  logic                 n_has_r_s;
  logic [IDX_WIDTH-1:0] n_left_s;
  logic [IDX_WIDTH-1:0] n_right_s;
  logic                 in_decode_s;
  logic                 both_s;
  logic                 push_s;
  logic                 start_ok_s;
  logic                 done_s;

  assign n_leaf_s  = node_rdata[NODE_WIDTH-1];
  assign n_has_l_s = node_rdata[NODE_WIDTH-2];
  assign n_has_r_s = node_rdata[NODE_WIDTH-3];
  assign n_left_s  = node_rdata[2*IDX_WIDTH-1:IDX_WIDTH];
  assign n_right_s = node_rdata[IDX_WIDTH-1:0];

  // The node word only exists during DECODE, so visit and push strobes are decoded from it in that cycle.
  assign in_decode_s = !reset && (state_q == DECODE);
  assign both_s      = n_has_l_s && n_has_r_s;
  assign push_s      = in_decode_s && both_s && !stk_full;
  assign start_ok_s  = !reset && (state_q == IDLE) && start && stk_empty;
  assign done_s      = (!reset && (state_q == IDLE) && start && !stk_empty)
                     || (in_decode_s && ((both_s && stk_full) || (!n_has_l_s && !n_has_r_s && stk_empty)));

  assign node_rd_en  = node_rd_en_q;
  assign node_addr   = node_addr_q;
  assign stk_push    = push_s;
  assign stk_pop     = stk_pop_q;
  assign stk_din     = push_s ? n_right_s : {IDX_WIDTH{1'b0}};
  assign visit_valid = in_decode_s;
  assign visit_idx   = in_decode_s ? cur_q : {IDX_WIDTH{1'b0}};
  assign visit_leaf  = in_decode_s && n_leaf_s;
  assign busy        = busy_q;
  assign done        = done_s;
  assign err         = err_q;

  // Traversal state machine; the next fetch address and read strobe are registered on the transition into FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_q        <= {IDX_WIDTH{1'b0}};
      node_addr_q  <= {IDX_WIDTH{1'b0}};
      node_rd_en_q <= 1'b0;
      stk_pop_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      node_rd_en_q <= 1'b0;
      stk_pop_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && stk_empty) begin
            cur_q        <= root_idx;
            node_addr_q  <= root_idx;
            node_rd_en_q <= 1'b1;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= FETCH;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        FETCH: state_q <= DECODE;
        DECODE: begin
          if (both_s && stk_full) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (n_has_l_s) begin
            cur_q        <= n_left_s;
            node_addr_q  <= n_left_s;
            node_rd_en_q <= 1'b1;
            state_q      <= FETCH;
          end else if (n_has_r_s) begin
            cur_q        <= n_right_s;
            node_addr_q  <= n_right_s;
            node_rd_en_q <= 1'b1;
            state_q      <= FETCH;
          end else if (stk_empty) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            stk_pop_q <= 1'b1;
            state_q   <= POP;
          end
        end
        POP: state_q <= POP_WAIT;
        POP_WAIT: begin
          if (stk_just_popped) begin
            cur_q        <= stk_dout;
            node_addr_q  <= stk_dout;
            node_rd_en_q <= 1'b1;
            state_q      <= FETCH;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DFS_VISIT_COUNT_EN
  logic [IDX_WIDTH:0] visit_count_q;

  assign visit_count = visit_count_q;

  // Saturating count of visits since the last accepted start.
  always_ff @(posedge clk) begin
    if (reset || start_ok_s) begin
      visit_count_q <= {(IDX_WIDTH+1){1'b0}};
    end else if (in_decode_s && (visit_count_q != {(IDX_WIDTH+1){1'b1}})) begin
      visit_count_q <= visit_count_q + {{IDX_WIDTH{1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_dfs_walker.sv
// Scoreboard bench for dfs_walker: node memory and LIFO models, preorder reference model, directed and random trees.
module tb_dfs_walker;
  localparam int IW = 8;
  localparam int NW = 2*IW+3;

  typedef struct packed {
    logic          kind;   // 0 = visit, 1 = done
    logic [IW-1:0] idx;
    logic          leaf;
    logic          err;
  } sb_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] root_idx = '0;
  logic          node_rd_en;
  logic [IW-1:0] node_addr;
  logic [NW-1:0] node_rdata = '0;
  logic          stk_push;
  logic          stk_pop;
  logic [IW-1:0] stk_din;
  logic [IW-1:0] stk_dout = '0;
  logic          stk_just_popped = 1'b0;
  logic          stk_full;
  logic          stk_empty;
  logic          visit_valid;
  logic [IW-1:0] visit_idx;
  logic          visit_leaf;
  logic          busy;
  logic          done;
  logic          err;
`ifdef DFS_VISIT_COUNT_EN
  logic [IW:0]   visit_count;
`endif

  int  checks = 0;
  int  errors = 0;
  int  push_cnt = 0;
  int  pop_cnt = 0;
  sb_t sb[$];

  logic [NW-1:0] mem [256];
  logic [IW-1:0] stack[$];
  int            cnt_q = 0;
  int            stk_depth = 4;
  bit            hold_pop = 1'b0;
  bit            tb_clear = 1'b0;
  bit            tb_preload = 1'b0;
  bit            pend_q = 1'b0;
  int            pw_q = 0;
  logic [IW-1:0] pv_q = '0;

  always #5 clk = ~clk;

  dfs_walker #(.IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .root_idx(root_idx),
    .node_rd_en(node_rd_en), .node_addr(node_addr), .node_rdata(node_rdata),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
    .stk_just_popped(stk_just_popped), .stk_full(stk_full), .stk_empty(stk_empty),
    .visit_valid(visit_valid), .visit_idx(visit_idx), .visit_leaf(visit_leaf),
    .busy(busy), .done(done), .err(err)
`ifdef DFS_VISIT_COUNT_EN
    , .visit_count(visit_count)
`endif
  );

  // Node memory: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (node_rd_en) node_rdata <= mem[node_addr];
    else            node_rdata <= NW'($urandom);
  end

  assign stk_empty = (cnt_q == 0);
  assign stk_full  = (cnt_q >= stk_depth);

  // External LIFO with a random 0..3 cycle pop response.
  always @(posedge clk) begin
    stk_just_popped <= 1'b0;
    if (tb_clear) begin
      stack.delete();
      cnt_q  <= 0;
      pend_q <= 1'b0;
    end else if (tb_preload) begin
      stack.delete();
      stack.push_back(8'h55);
      cnt_q  <= 1;
      pend_q <= 1'b0;
    end else begin
      if (stk_push) stack.push_back(stk_din);
      if (stk_pop) begin
        if (!hold_pop && ($urandom_range(0, 1) == 0)) begin
          stk_just_popped <= 1'b1;
          stk_dout        <= stack[$];
        end else begin
          pend_q <= 1'b1;
          pw_q   <= $urandom_range(0, 2);
          pv_q   <= stack[$];
        end
        void'(stack.pop_back());
      end
      cnt_q <= cnt_q + (stk_push ? 1 : 0) - (stk_pop ? 1 : 0);
      if (pend_q) begin
        if (pw_q > 0) begin
          pw_q <= pw_q - 1;
        end else if (!hold_pop) begin
          stk_just_popped <= 1'b1;
          stk_dout        <= pv_q;
          pend_q          <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk(input bit leaf, input bit hl, input bit hr,
                                       input logic [IW-1:0] l, input logic [IW-1:0] r);
    return {leaf, hl, hr, l, r};
  endfunction

  function automatic void push_visit(input logic [IW-1:0] idx);
    sb_t e;
    e.kind = 1'b0; e.idx = idx; e.leaf = mem[idx][NW-1]; e.err = 1'b0;
    sb.push_back(e);
  endfunction

  // Reference: preorder walk with a bounded explicit stack; returns visit count and error flag.
  function automatic int model(input logic [IW-1:0] root, input int depth, output bit ferr);
    logic [IW-1:0] st[$];
    logic [IW-1:0] c;
    logic [NW-1:0] w;
    int            n;
    bit            fin;
    sb_t           e;
    n = 0; fin = 1'b0; ferr = 1'b0; c = root;
    while (!fin && n < 1000) begin
      w = mem[c];
      push_visit(c);
      n++;
      if (w[NW-2] && w[NW-3]) begin
        if (st.size() >= depth) begin
          ferr = 1'b1; fin = 1'b1;
        end else begin
          st.push_back(w[IW-1:0]);
          c = w[2*IW-1:IW];
        end
      end else if (w[NW-2]) c = w[2*IW-1:IW];
      else if (w[NW-3]) c = w[IW-1:0];
      else if (st.size() == 0) fin = 1'b1;
      else c = st.pop_back();
    end
    e.kind = 1'b1; e.idx = '0; e.leaf = 1'b0; e.err = ferr;
    sb.push_back(e);
    return n;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a visit or done.
  initial begin
    bit   pend;
    logic experr;
    sb_t  e;
    pend = 1'b0;
    experr = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        chk("err_after_done", err, experr);
        pend = 1'b0;
      end
      if (stk_push && stk_pop) chk("push_pop_exclusive", 1, 0);
      if (stk_push) push_cnt++;
      if (stk_pop) pop_cnt++;
      if (visit_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_visit", visit_idx, 32'hffff);
        end else begin
          e = sb.pop_front();
          chk("visit_kind", 0, e.kind);
          chk("visit_idx", visit_idx, e.idx);
          chk("visit_leaf", visit_leaf, e.leaf);
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_kind", 1, e.kind);
          pend = 1'b1;
          experr = e.err;
        end
      end
    end
  end

  task automatic do_start(input logic [IW-1:0] r);
    @(posedge clk); #1 root_idx = r; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (done) begin lat = i; ok = 1'b1; break; end
    end
  endtask

  task automatic clear_stack();
    @(posedge clk); #1 tb_clear = 1'b1;
    @(posedge clk); #1 tb_clear = 1'b0;
  endtask

  task automatic run_tree(input logic [IW-1:0] root, input int depth, input bit poke, output int lat);
    int n;
    bit me;
    bit ok;
    stk_depth = depth;
    n = model(root, depth, me);
    do_start(root);
    if (poke && n >= 2) begin
      @(posedge clk); #1 start = 1'b1; root_idx = IW'($urandom);
      @(posedge clk); #1 start = 1'b0;
    end
    wait_done(lat, ok);
    chk("done_seen", ok, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
`ifdef DFS_VISIT_COUNT_EN
    chk("visit_count", visit_count, n);
`endif
    clear_stack();
  endtask

  task automatic build_random(output logic [IW-1:0] root);
    int            n;
    int            base;
    int            lc[16];
    int            rc[16];
    logic [IW-1:0] ad[16];
    n = $urandom_range(1, 12);
    base = $urandom_range(0, 255);
    for (int k = 0; k < n; k++) begin
      ad[k] = IW'(base + 7*k); lc[k] = -1; rc[k] = -1;
    end
    for (int k = 1; k < n; k++) begin
      int p;
      p = $urandom_range(0, k-1);
      while (lc[p] >= 0 && rc[p] >= 0) p = (p + 1) % k;
      if (lc[p] < 0 && (rc[p] >= 0 || $urandom_range(0, 1) == 1)) lc[p] = k;
      else rc[p] = k;
    end
    for (int k = 0; k < n; k++) begin
      mem[ad[k]] = mk(1'($urandom), lc[k] >= 0, rc[k] >= 0,
                      (lc[k] >= 0) ? ad[lc[k]] : IW'($urandom),
                      (rc[k] >= 0) ? ad[rc[k]] : IW'($urandom));
    end
    root = ad[0];
  endtask

  initial begin
    int            lat;
    int            p0;
    int            q0;
    bit            ok;
    logic [IW-1:0] r;
    sb_t           e;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", node_rd_en, 0);
    chk("rst_push_pop", {stk_push, stk_pop}, 0);
    chk("rst_visit", visit_valid, 0);
    chk("rst_busy_done_err", {busy, done, err}, 0);
    chk("rst_addr_din_idx", {node_addr, stk_din, visit_idx}, 0);

    // Single leaf root 5
    mem[5] = mk(1, 0, 0, 8'd0, 8'd0);
    p0 = push_cnt; q0 = pop_cnt;
    run_tree(8'd5, 4, 1'b0, lat);
    chk("leaf_latency", lat, 2);
    chk("leaf_stack_ops", (push_cnt - p0) + (pop_cnt - q0), 0);

    // Three-node tree
    mem[0] = mk(0, 1, 1, 8'd1, 8'd2);
    mem[1] = mk(1, 0, 0, 8'd0, 8'd0);
    mem[2] = mk(1, 0, 0, 8'd0, 8'd0);
    p0 = push_cnt; q0 = pop_cnt;
    run_tree(8'd0, 4, 1'b0, lat);
    chk("tree3_pushes", push_cnt - p0, 1);
    chk("tree3_pops", pop_cnt - q0, 1);

    // Left-only chain 0->3->7
    mem[0] = mk(0, 1, 0, 8'd3, 8'd9);
    mem[3] = mk(0, 1, 0, 8'd7, 8'd9);
    mem[7] = mk(1, 0, 0, 8'd0, 8'd0);
    p0 = push_cnt; q0 = pop_cnt;
    run_tree(8'd0, 4, 1'b0, lat);
    chk("chain_latency", lat, 6);
    chk("chain_stack_ops", (push_cnt - p0) + (pop_cnt - q0), 0);

    // Stack full at a two-child root
    mem[0] = mk(0, 1, 1, 8'd1, 8'd2);
    p0 = push_cnt;
    run_tree(8'd0, 0, 1'b0, lat);
    chk("full_latency", lat, 2);
    chk("full_no_push", push_cnt - p0, 0);

    // Reset while waiting for a pop response
    stk_depth = 4;
    hold_pop = 1'b1;
    push_visit(8'd0);
    push_visit(8'd1);
    do_start(8'd0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stk_pop) begin ok = 1'b1; break; end
    end
    chk("pop_seen", ok, 1);
    @(posedge clk); #1 reset = 1'b1; tb_clear = 1'b1;
    @(posedge clk); #1 reset = 1'b0; tb_clear = 1'b0; hold_pop = 1'b0;
    chk("rst_mid_strobes", {node_rd_en, stk_push, stk_pop, visit_valid, done}, 0);
    chk("rst_mid_busy_err", {busy, err}, 0);
    chk("rst_mid_sb_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
    p0 = push_cnt; q0 = pop_cnt;
    run_tree(8'd0, 4, 1'b0, lat);
    chk("after_rst_stack_ops", (push_cnt - p0) + (pop_cnt - q0), 2);

    // Start with a non-empty stack
    @(posedge clk); #1 tb_preload = 1'b1;
    @(posedge clk); #1 tb_preload = 1'b0;
    e.kind = 1'b1; e.idx = '0; e.leaf = 1'b0; e.err = 1'b1;
    sb.push_back(e);
    root_idx = 8'd0; start = 1'b1;
    @(negedge clk);
    chk("nonempty_done", done, 1);
    chk("nonempty_no_read", node_rd_en, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("nonempty_idle", {busy, node_rd_en}, 0);
    chk("nonempty_err", err, 1);
    clear_stack();

    // Random trees with random stack depth and a start pulse while busy
    for (int t = 0; t < 40; t++) begin
      build_random(r);
      run_tree(r, $urandom_range(1, 4), 1'b1, lat);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty_at_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/dfs_walker.md
DFS_WALKER -- requirements
Module: dfs_walker

Interface
REQ-001 SHALL have parameter IDX_WIDTH, default 8: width of a node index.
REQ-002 SHALL have parameter NODE_WIDTH, default 2*IDX_WIDTH+3: node word layout {is_leaf, has_left, has_right, left_idx, right_idx}, MSB first.
REQ-003 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse beginning a traversal from root_idx.
REQ-006 SHALL have port root_idx  in  IDX_WIDTH  root node index, sampled on an accepted start.
REQ-007 SHALL have port node_rd_en  out  1  node memory read strobe.
REQ-008 SHALL have port node_addr  out  IDX_WIDTH  node memory read address.
REQ-009 SHALL have port node_rdata  in  NODE_WIDTH  node word, valid exactly 1 cycle after node_rd_en.
REQ-010 SHALL have port stk_push  out  1  push strobe to the external LIFO.
REQ-011 SHALL have port stk_pop  out  1  pop strobe to the external LIFO.
REQ-012 SHALL have port stk_din  out  IDX_WIDTH  index to push.
REQ-013 SHALL have port stk_dout  in  IDX_WIDTH  popped index, valid while stk_just_popped=1.
REQ-014 SHALL have ports stk_just_popped, stk_full, stk_empty  in  1 each  LIFO status.
REQ-015 SHALL have port visit_valid  out  1  one-cycle pulse per visited node.
REQ-016 SHALL have ports visit_idx  out  IDX_WIDTH and visit_leaf  out  1  visited node index and its is_leaf bit.
REQ-017 SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), err  out  1 (sticky until next accepted start).

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, DECODE, POP, POP_WAIT.
REQ-019 IDLE: start=1 and stk_empty=1 -> cur<=root_idx, err<=0, go FETCH; start=1 and stk_empty=0 -> err<=1, done pulse, stay IDLE.
REQ-020 FETCH: node_rd_en=1, node_addr=cur; next state DECODE.
REQ-021 DECODE: visit_valid=1, visit_idx=cur, visit_leaf=node_rdata is_leaf; traversal is preorder, left before right.
REQ-022 DECODE, both children: stk_push=1, stk_din=right_idx, cur<=left_idx, go FETCH; if stk_full=1, no push, err<=1, done pulse, go IDLE.
REQ-023 DECODE, exactly one child: cur<=that child, go FETCH, no stack access.
REQ-024 DECODE, no children: stk_empty=1 -> done pulse, go IDLE; else go POP.
REQ-025 POP: stk_pop=1 for exactly one cycle, go POP_WAIT.
REQ-026 POP_WAIT: on stk_just_popped=1, cur<=stk_dout, go FETCH; otherwise hold with no strobes.
REQ-027 stk_push and stk_pop SHALL never be asserted in the same cycle.
REQ-028 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-029 Per-node latency: 2 cycles FETCH->DECODE; a pop adds POP + POP_WAIT (minimum 2 cycles).

Reset
REQ-030 reset SHALL force IDLE and drive node_rd_en, stk_push, stk_pop, visit_valid, busy, done, err to 0; cur, node_addr, stk_din and visit_idx to 0.
REQ-031 reset mid-traversal SHALL abandon it without a done pulse; clearing the stack is the owner's responsibility.

Configuration
REQ-032 With DFS_VISIT_COUNT_EN defined, SHALL add output visit_count (IDX_WIDTH+1 bits): cleared on accepted start and on reset, +1 per visit_valid, saturates at all-ones.
REQ-033 Without DFS_VISIT_COUNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Single leaf root 5 (is_leaf=1, no children), start -> one visit idx 5 leaf=1, done 2 cycles after start, no push or pop.
REQ-035 Tree 0:{L1,R2}, 1 and 2 leaves -> visits 0,1,2 in order; one push of 2, one pop; done, err=0.
REQ-036 Chain 0->3->7 (left only) -> visits 0,3,7, no stack access, done 6 cycles after start.
REQ-037 Stack full (stk_full=1) at node with two children -> no push, err=1, done pulse, back to IDLE.
REQ-038 reset asserted in POP_WAIT -> next cycle IDLE, all strobes 0, busy=0, no done; new start then traverses normally.
REQ-039 start with stk_empty=0 -> err=1, done pulse, no node_rd_en; with DFS_VISIT_COUNT_EN on the 3-node tree -> visit_count=3.
